// File: rtl/sram_bank.sv
`timescale 1ns/1ps
// Single-port synchronous SRAM bank with valid/ready request/response,
// byte strobes, post-reset zero-fill sweep and out-of-range error count.
module sram_bank #(
   parameter int DATAWIDTH  = 32,
   parameter int ADDRWIDTH  = 10,
   parameter int DEPTH      = 1 << ADDRWIDTH,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDRWIDTH-1:0]   req_addr,
   input  logic [DATAWIDTH/8-1:0] req_we,
   input  logic [DATAWIDTH-1:0]   req_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATAWIDTH-1:0]   rsp_rdata,
   output logic                   rsp_err,
   output logic                   init_done,
   output logic [15:0]            err_count
);

   localparam int NB = DATAWIDTH / 8;
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDRWIDTH-1:0]   icnt_q, icnt_d;
   logic                   init_done_q, init_done_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [15:0]            err_count_q, err_count_d;

   logic [DATAWIDTH-1:0]   mem [DEPTH];

   logic acc;
   logic in_range;
   logic is_rd;
   logic sweep_last;

   always_comb begin
      in_range    = 32'(req_addr) < DEPTH_U;
      sweep_last  = 32'(icnt_q) == (DEPTH_U - 32'd1);
      is_rd       = ~|req_we;
      req_ready   = (state_q == RUN) & (~rsp_valid_q | rsp_ready);
      acc         = req_valid & req_ready;

      state_d     = state_q;
      icnt_d      = icnt_q;
      init_done_d = init_done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      err_count_d = err_count_q;

      if (state_q == INIT) begin
         icnt_d = icnt_q + ADDRWIDTH'(1);
         if (sweep_last) begin
            state_d     = RUN;
            init_done_d = 1'b1;
            icnt_d      = '0;
         end
      end

      // Single output slot: a pop and a new accept may share one edge.
      if (acc) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = ~in_range;
         rsp_rdata_d = (in_range & is_rd) ? mem[req_addr] : '0;
         if (~in_range && err_count_q != 16'hFFFF)
            err_count_d = err_count_q + 16'd1;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= INIT_CLEAR ? INIT : RUN;
         icnt_q      <= '0;
         init_done_q <= ~INIT_CLEAR;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         icnt_q      <= icnt_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         err_count_q <= err_count_d;
      end
   end

   // Storage has no reset; only the sweep clears it.
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem[icnt_q] <= '0;
      end else if (acc & in_range & ~is_rd) begin
         for (int k = 0; k < NB; k++) begin
            if (req_we[k])
               mem[req_addr][8*k +: 8] <= req_wdata[8*k +: 8];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign init_done = init_done_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_sram_bank.sv
`timescale 1ns/1ps
// Randomised bench for sram_bank against a transaction-level model
// (word array plus expected-response queue).
module tb_sram_bank;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DP = 12;

   logic          clk = 1'b0;
   logic          rstn;

   logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
   logic          init_done;
   logic [AW-1:0] req_addr;
   logic [3:0]    req_we;
   logic [DW-1:0] req_wdata, rsp_rdata;
   logic [15:0]   err_count;

   logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
   logic          b_rsp_err, b_init_done;
   logic [AW-1:0] b_req_addr;
   logic [3:0]    b_req_we;
   logic [DW-1:0] b_req_wdata, b_rsp_rdata;
   logic [15:0]   b_err_count;

   int n_chk = 0;
   int n_fail = 0;

   logic [31:0] mm [16];
   logic [32:0] q [$];
   logic [15:0] ecnt;
   logic        running;

   always #5 clk = ~clk;

   sram_bank #(
      .DATAWIDTH(DW), .ADDRWIDTH(AW), .DEPTH(DP), .INIT_CLEAR(1'b1)
   ) u_dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .init_done(init_done), .err_count(err_count)
   );

   sram_bank #(
      .DATAWIDTH(DW), .ADDRWIDTH(AW), .DEPTH(DP), .INIT_CLEAR(1'b0)
   ) u_dut_b (
      .clk(clk), .rstn(rstn),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr(b_req_addr), .req_we(b_req_we), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .init_done(b_init_done), .err_count(b_err_count)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      ecnt = '0;
      for (int j = 0; j < 16; j++) mm[j] = '0;
   endtask

   // One cycle: drive, check outputs against the model, advance the model.
   task automatic drive(input logic v, input logic [3:0] a,
                        input logic [3:0] we, input logic [31:0] wd,
                        input logic rr, output logic [31:0] ord,
                        output logic oerr, output logic oacc);
      logic        er;
      logic [32:0] e;
      @(negedge clk);
      req_valid = v;
      req_addr  = a;
      req_we    = we;
      req_wdata = wd;
      rsp_ready = rr;
      #1;
      ord  = rsp_rdata;
      oerr = rsp_err;
      er   = running && (q.size() == 0 || rr);
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("rsp_rdata", rsp_rdata, q[0][31:0]);
         chk("rsp_err", rsp_err, q[0][32]);
      end
      chk("err_count", err_count, ecnt);
      oacc = v && er;
      if (q.size() != 0 && rr) void'(q.pop_front());
      if (oacc) begin
         if (a >= DP) begin
            e = {1'b1, 32'h0};
            if (ecnt != 16'hFFFF) ecnt = ecnt + 16'd1;
         end else if (we == 4'h0) begin
            e = {1'b0, mm[a]};
         end else begin
            e = {1'b0, 32'h0};
            for (int k = 0; k < 4; k++)
               if (we[k]) mm[a][8*k +: 8] = wd[8*k +: 8];
         end
         q.push_back(e);
      end
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0;
      req_addr  = '0;
      req_we    = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
   endtask

   task automatic wait_init();
      for (int i = 1; i <= DP; i++) begin
         @(posedge clk);
         #1;
         chk("init_done", init_done, i == DP);
         chk("init_ready", req_ready, i == DP);
      end
      running = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        ac;

      rstn = 1'b0;
      running = 1'b0;
      idle_inputs();
      b_req_valid = 1'b0;
      b_req_addr  = '0;
      b_req_we    = '0;
      b_req_wdata = '0;
      b_rsp_ready = 1'b1;
      model_clear();
      #23;

      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_err_count", err_count, 0);
      chk("b_rst_req_ready", b_req_ready, 1);
      chk("b_rst_init_done", b_init_done, 1);
      chk("b_rst_rsp_valid", b_rsp_valid, 0);

      @(negedge clk);
      rstn = 1'b1;
      wait_init();

      for (int a = 0; a < DP; a++) begin
         drive(1'b1, 4'(a), 4'h0, 32'h0, 1'b1, rd, er, ac);
         if (a > 0) chk("sweep_zero", rd, 0);
      end
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("sweep_zero_last", rd, 0);

      drive(1'b1, 4'd3, 4'hF, 32'hAABBCCDD, 1'b1, rd, er, ac);
      drive(1'b1, 4'd3, 4'h5, 32'h11223344, 1'b1, rd, er, ac);
      drive(1'b1, 4'd3, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("bs_wr_rdata", rd, 0);
      drive(1'b1, 4'd3, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("bs_rd_next", rd, 32'hAA22CC44);
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("bs_rd", rd, 32'hAA22CC44);

      drive(1'b1, 4'd13, 4'h0, 32'h0, 1'b1, rd, er, ac);
      drive(1'b1, 4'd15, 4'hF, 32'hFFFFFFFF, 1'b1, rd, er, ac);
      chk("oor_rd_err", er, 1);
      chk("oor_rd_data", rd, 0);
      drive(1'b1, 4'd11, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("oor_wr_err", er, 1);
      chk("oor_wr_data", rd, 0);
      chk("oor_err_count", err_count, 2);
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("oor_addr11", rd, 0);
      chk("oor_addr11_err", er, 0);

      drive(1'b1, 4'd1, 4'hF, 32'h00000101, 1'b1, rd, er, ac);
      drive(1'b1, 4'd2, 4'hF, 32'h00000202, 1'b1, rd, er, ac);
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, rd, er, ac);
      drive(1'b1, 4'd1, 4'h0, 32'h0, 1'b0, rd, er, ac);
      chk("bp_acc1", ac, 1);
      drive(1'b1, 4'd2, 4'h0, 32'h0, 1'b0, rd, er, ac);
      chk("bp_block", req_ready, 0);
      chk("bp_rd1", rd, 32'h101);
      drive(1'b1, 4'd2, 4'h0, 32'h0, 1'b0, rd, er, ac);
      chk("bp_hold", rd, 32'h101);
      drive(1'b1, 4'd2, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("bp_acc2", ac, 1);
      chk("bp_rd1_pop", rd, 32'h101);
      drive(1'b1, 4'd3, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("bp_rd2", rd, 32'h202);
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("bp_rd3", rd, 32'hAA22CC44);

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0,
               4'($urandom_range(0, 15)),
               $urandom_range(0, 1) ? 4'($urandom) : 4'h0,
               $urandom,
               $urandom_range(0, 3) != 0,
               rd, er, ac);
      end
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, rd, er, ac);
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, rd, er, ac);

      drive(1'b1, 4'd5, 4'hF, 32'hDEADBEEF, 1'b1, rd, er, ac);
      chk("mid_acc", ac, 1);
      @(posedge clk);
      #1;
      idle_inputs();
      chk("pre_rst_valid", rsp_valid, 1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_ready", req_ready, 0);
      running = 1'b0;
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      wait_init();
      drive(1'b1, 4'd5, 4'h0, 32'h0, 1'b1, rd, er, ac);
      drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, rd, er, ac);
      chk("mid_rd5", rd, 0);

      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_addr  = 4'd0;
      b_req_we    = 4'hF;
      b_req_wdata = 32'h12345678;
      #1;
      chk("b_ready", b_req_ready, 1);
      @(negedge clk);
      b_req_we = 4'h0;
      #1;
      chk("b_wr_valid", b_rsp_valid, 1);
      chk("b_wr_rdata", b_rsp_rdata, 0);
      @(negedge clk);
      b_req_valid = 1'b0;
      #1;
      chk("b_rd_valid", b_rsp_valid, 1);
      chk("b_rd_rdata", b_rsp_rdata, 32'h12345678);
      @(negedge clk);
      #1;
      chk("b_idle_valid", b_rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_bank.md
# sram_bank

Parametrised single-port synchronous SRAM bank. It has a valid/ready request and response handshake, per-byte write strobes, a post-reset zero-fill sweep and out-of-range error reporting. It replaces the flat combinational-read memory model as the on-chip memory behind bus slaves. Reads are registered, with one cycle of latency. Throughput is one request per cycle while the response side is not stalled.

## Interface
- DATAWIDTH, 32, data width in bits; must be a multiple of 8; NB = DATAWIDTH/8 byte lanes
- ADDRWIDTH, 10, word-address width
- DEPTH, 1<<ADDRWIDTH, number of implemented words, 1..2^ADDRWIDTH
- INIT_CLEAR, 1, 1 = zero-fill sweep after reset; 0 = contents left undefined, ready immediately
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  bank can accept a request this cycle
- req_addr  in  ADDRWIDTH  word address
- req_we  in  NB  byte write strobes; all-zero = read
- req_wdata  in  DATAWIDTH  write data, lane k = bits [8k+7:8k]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and errors
- rsp_err  out  1  address >= DEPTH
- init_done  out  1  zero-fill finished
- err_count  out  16  saturating count of error responses

## Operation
- FSM states: INIT, RUN. rstn low forces INIT if INIT_CLEAR=1, otherwise RUN.
- INIT: on each edge, write mem[icnt] = 0 and increment icnt (reset value 0). The edge that writes icnt == DEPTH-1 moves the FSM to RUN. req_ready = 0 throughout INIT.
- RUN: req_ready = ~rsp_valid | rsp_ready (single-entry output register with pass-through on pop).
- Accept = req_valid & req_ready. Each accepted request produces exactly one response. Reads and writes are treated alike in this respect.
- Read (req_we == 0, addr < DEPTH): on the next edge rsp_rdata = mem[addr] and rsp_err = 0.
- Write (req_we != 0, addr < DEPTH): on the next edge, each lane k with req_we[k] = 1 gets req_wdata lane k. Lanes with req_we[k] = 0 are unchanged. rsp_rdata = 0, rsp_err = 0.
- Address >= DEPTH: no memory access. rsp_rdata = 0, rsp_err = 1, err_count increments and saturates at 0xFFFF.
- When rsp_valid & ~rsp_ready, rsp_valid, rsp_rdata and rsp_err hold stable and req_ready = 0.
- On a cycle with rsp_ready = 1 and no accept, rsp_valid clears on the next edge.
- Write data is visible to a read accepted on the following cycle; there is no stale-read window.
- Memory contents are not reset directly. They are cleared only by the INIT sweep.

## Timing
- Reset values: req_ready 0 (INIT_CLEAR=1) or 1 (INIT_CLEAR=0), rsp_valid 0, rsp_rdata 0, rsp_err 0, init_done = ~INIT_CLEAR, err_count 0, icnt 0.
- INIT lasts exactly DEPTH rising edges after rstn deasserts. init_done and req_ready rise together after the DEPTH-th edge.
- Latency: request accepted at edge N gives rsp_valid = 1 after edge N+1. Back-to-back accepts give one response per cycle.
- Reset asserted mid-operation: pending response is dropped immediately (rsp_valid 0 asynchronously), any in-flight write is not performed, and the sweep restarts from 0.
- Reset during INIT: icnt returns to 0 and the sweep restarts.
- err_count updates on the same edge that loads the error response.

## Test plan
- Init sweep (DATAWIDTH=32, ADDRWIDTH=4, DEPTH=12): release rstn, then count edges -> init_done and req_ready go high after edge 12. Read all addresses 0..11 -> each returns 0x00000000, rsp_err 0.
- Byte strobes: write 0xAABBCCDD to addr 3 with we=0xF, then 0x11223344 with we=0x5, then read addr 3 -> 0xAA22CC44. Read accepted the cycle right after the last write also returns 0xAA22CC44.
- Out of range: read addr 13, then write addr 15 -> two responses, rsp_err=1, rdata 0, err_count=2. Addr 11 remains untouched.
- Backpressure: issue reads of addr 1, 2, 3 back-to-back with rsp_ready=0 for 3 cycles -> req_ready=0 after the first accept. Response for addr 1 is held stable, and the three responses arrive in order once rsp_ready=1, at one per cycle.
- Reset mid-op: accept a write of 0xDEADBEEF to addr 5 and assert rstn low before the next edge -> rsp_valid drops immediately, the sweep reruns, and a subsequent read of addr 5 returns 0.
- INIT_CLEAR=0: after reset, req_ready=1 and init_done=1 immediately. Write then read addr 0 -> data returns after 1 cycle.
